program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_program_loader.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Receives a program image over a byte stream and writes it into the CPU's
//   instruction memory while holding the CPU in reset. The image is a 16-bit
//   big-endian word count followed by that many 5-byte instruction words,
//   most-significant byte first. The top two bits of each word's first byte
//   must be zero. A bad count or a bad first byte aborts the load and sets a
//   sticky error flag.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle load request, honoured only while idle
//   rx_data      incoming byte
//   rx_valid     rx_data valid (transfer when rx_valid && rx_ready)
//   rx_ready     loader can accept a byte
//   mem_we       instruction memory write strobe (one cycle per word)
//   mem_addr     instruction memory write address
//   mem_wdata    assembled instruction word
//   cpu_hold     keeps the CPU in reset while a load is running
//   busy         load in progress
//   done         one-cycle pulse on successful completion
//   err          sticky error, cleared by the next accepted start
//   words_loaded words written by the current / last load
// -----------------------------------------------------------------------------

// Protocol checker: invariants on the loader's outputs, kept out of the logic.
module program_loader_checker #(
  parameter int ADDR_WIDTH = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  rx_ready,
  input logic                  mem_we,
  input logic                  cpu_hold,
  input logic                  busy,
  input logic                  done,
  input logic [ADDR_WIDTH:0]   words_loaded
);

  // A write cycle never accepts a byte and always belongs to a running load.
  a_we_excl : assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> (!rx_ready && busy));

  // The completion cycle neither writes nor accepts bytes.
  a_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (!mem_we && !rx_ready && busy));

  // The CPU hold tracks the busy indication exactly.
  a_hold_busy : assert property (@(posedge clk) disable iff (!rst_n)
    busy == cpu_hold);

  // Bytes are only accepted while a load is running.
  a_ready_busy : assert property (@(posedge clk) disable iff (!rst_n)
    rx_ready |-> busy);

  // Write strobe and done are single-cycle pulses.
  a_we_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |=> !mem_we);
  a_done_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    done |=> (!done && !busy));

  // The word counter can never exceed the memory depth.
  a_words_max : assert property (@(posedge clk) disable iff (!rst_n)
    words_loaded <= {1'b1, {ADDR_WIDTH{1'b0}}});

endmodule

module program_loader #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  // Largest legal word count is the full memory depth.
  localparam logic [16:0] MAX_COUNT = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            hdr_hi_q, hdr_hi_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [2:0]            byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]      words_loaded_q, words_loaded_d;
  logic                  err_q, err_d;

  // Output flops: decoded from the next state so they align with state_q.
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  handshake_s;
  logic [15:0]           hdr_count_s;
  logic                  hdr_bad_s;

  assign handshake_s = rx_valid && rx_ready_q;
  // Full header word as it is seen during the low-byte handshake.
  assign hdr_count_s = {hdr_hi_q, rx_data};
  assign hdr_bad_s   = (hdr_count_s == 16'd0) || ({1'b0, hdr_count_s} > MAX_COUNT);

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      hdr_hi_q       <= 8'd0;
      remaining_q    <= '0;
      byte_idx_q     <= 3'd0;
      word_q         <= '0;
      mem_addr_q     <= '0;
      words_loaded_q <= '0;
      err_q          <= 1'b0;
      rx_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_hi_q       <= hdr_hi_d;
      remaining_q    <= remaining_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      mem_addr_q     <= mem_addr_d;
      words_loaded_q <= words_loaded_d;
      err_q          <= err_d;
      rx_ready_q     <= rx_ready_d;
      mem_we_q       <= mem_we_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d        = state_q;
    hdr_hi_d       = hdr_hi_q;
    remaining_d    = remaining_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    mem_addr_d     = mem_addr_q;
    words_loaded_d = words_loaded_q;
    err_d          = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_HDR_HI;
          err_d          = 1'b0;
          mem_addr_d     = '0;
          words_loaded_d = '0;
          byte_idx_d     = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HDR_HI: begin
        if (handshake_s) begin
          hdr_hi_d = rx_data;
          state_d  = S_HDR_LO;
        end else begin
          state_d = S_HDR_HI;
        end
      end

      S_HDR_LO: begin
        if (handshake_s) begin
          if (hdr_bad_s) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Count is known to fit: it is at most the memory depth.
            remaining_d = CNT_W'(hdr_count_s);
            byte_idx_d  = 3'd0;
            state_d     = S_DATA;
          end
        end else begin
          state_d = S_HDR_LO;
        end
      end

      S_DATA: begin
        if (handshake_s) begin
          if (byte_idx_q == 3'd0) begin
            // First byte carries only the six top bits of the word.
            if (rx_data[7:6] != 2'b00) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              word_d     = DATA_WIDTH'(rx_data[5:0]);
              byte_idx_d = 3'd1;
            end
          end else begin
            // Shift in MSB-first; after byte 4 the first byte lands on top.
            word_d = {word_q[DATA_WIDTH-9:0], rx_data};
            if (byte_idx_q == 3'd4) begin
              byte_idx_d = 3'd0;
              state_d    = S_WRITE;
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
            end
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_WRITE: begin
        // Saturate so a full-depth load leaves the address at the top word.
        if (mem_addr_q != {ADDR_WIDTH{1'b1}}) begin
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end else begin
          mem_addr_d = mem_addr_q;
        end
        words_loaded_d = words_loaded_q + CNT_W'(1);
        remaining_d    = remaining_q - CNT_W'(1);
        byte_idx_d     = 3'd0;
        if (remaining_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, registered alongside it.
  always_comb begin
    rx_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_HDR_HI, S_HDR_LO, S_DATA: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_we_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = word_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

  program_loader_checker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_ready     (rx_ready_q),
    .mem_we       (mem_we_q),
    .cpu_hold     (busy_q),
    .busy         (busy_q),
    .done         (done_q),
    .words_loaded (words_loaded_q)
  );

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. A reference model turns a word count
// and a list of raw 5-byte words into the byte stream plus the expected memory
// writes, error flag and word count. A monitor records every write and done
// pulse seen on the DUT outputs.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int DW = 38;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed behaviour.
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            done_cnt = 0;
  int            done_cyc = 0;

  // Model inputs and expectations.
  logic [39:0]   word_src[$];
  logic [7:0]    stream[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  bit            exp_err;
  bit            exp_done;
  int            exp_words;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
    if (rst_n && done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Reference model: header, 5-byte words, abort on bad count or first byte.
  function automatic void model_load(input int count);
    logic [39:0] raw;
    logic [7:0]  b0;
    longint      val;
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_err   = 1'b0;
    exp_done  = 1'b0;
    exp_words = 0;
    stream.push_back(8'(count >> 8));
    stream.push_back(8'(count));
    if (count == 0 || count > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < count; w++) begin
      raw = word_src[w];
      b0  = raw[39:32];
      stream.push_back(b0);
      if (b0 >= 8'd64) begin
        exp_err = 1'b1;
        return;
      end
      stream.push_back(raw[31:24]);
      stream.push_back(raw[23:16]);
      stream.push_back(raw[15:8]);
      stream.push_back(raw[7:0]);
      val = (longint'(b0) % 64) * 64'h1_0000_0000 + longint'(raw[31:0]);
      exp_addr.push_back(AW'(w));
      exp_data.push_back(DW'(val));
      exp_words = w + 1;
    end
    exp_done = 1'b1;
  endfunction

  function automatic logic [39:0] rand_word();
    return {8'($urandom_range(63, 0)), 32'($urandom)};
  endfunction

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit pulse);
    int n;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    start    = pulse;
    n = 0;
    while (rx_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int gap_max, input int start_at);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], gap_max, i == start_at);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({rx_ready, mem_we, cpu_hold, busy, done, err} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000", {rx_ready, mem_we, cpu_hold, busy, done, err});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0h wdata=%0h words=%0d required 0", mem_addr, mem_wdata, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    word_src.delete();
    word_src.push_back(40'h04_0000_0001);
    word_src.push_back(40'h00_0000_0000);
    model_load(2);
    clear_mon();
    pulse_start();
    n_checks++;
    if ({rx_ready, busy, cpu_hold, mem_we} !== 4'b1110) begin
      n_fail++;
      $display("FAIL basic_loading_flags: got %b required 1110", {rx_ready, busy, cpu_hold, mem_we});
    end
    send_stream(0, -1);
    wait_idle();
    n_checks++;
    if (got_addr.size() !== 2 || got_data.size() !== 2) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d required 2", got_addr.size());
    end else begin
      n_checks++;
      if (got_addr[0] !== 12'h000 || got_data[0] !== 38'h04_0000_0001) begin
        n_fail++;
        $display("FAIL basic_word0: got %0h@%0h required 0400000001@0", got_data[0], got_addr[0]);
      end
      n_checks++;
      if (got_addr[1] !== 12'h001 || got_data[1] !== 38'h0) begin
        n_fail++;
        $display("FAIL basic_word1: got %0h@%0h required 0@1", got_data[1], got_addr[1]);
      end
    end
    n_checks++;
    if (done_cnt !== 1 || words_loaded !== 13'd2 || err !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: done=%0d words=%0d err=%b hold=%b required 1 2 0 0", done_cnt, words_loaded, err, cpu_hold);
    end
  endtask

  task automatic test_bad_header(input int count, input string name);
    model_load(count);
    clear_mon();
    pulse_start();
    send_stream(0, -1);
    wait_idle();
    n_checks++;
    if (err !== exp_err || got_addr.size() !== 0 || cpu_hold !== 1'b0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL %s: err=%b writes=%0d hold=%b done=%0d required 1 0 0 0", name, err, got_addr.size(), cpu_hold, done_cnt);
    end
    // A good load afterwards: start clears err, then the data lands normally.
    word_src.delete();
    word_src.push_back(rand_word());
    model_load(1);
    clear_mon();
    pulse_start();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err_clear: err=%b required 0", name, err);
    end
    send_stream(0, -1);
    wait_idle();
    n_checks++;
    if (got_addr.size() !== 1 || got_data[0] !== exp_data[0] || got_addr[0] !== exp_addr[0]) begin
      n_fail++;
      $display("FAIL %s_reload: writes=%0d required 1 data %0h", name, got_addr.size(), exp_data[0]);
    end
  endtask

  task automatic test_bad_byte0();
    word_src.delete();
    word_src.push_back(40'hC4_0000_0000);
    model_load(1);
    clear_mon();
    pulse_start();
    send_stream(0, -1);
    wait_idle();
    n_checks++;
    if (err !== 1'b1 || got_addr.size() !== 0 || words_loaded !== '0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL bad_byte0_first: err=%b writes=%0d words=%0d done=%0d required 1 0 0 0", err, got_addr.size(), words_loaded, done_cnt);
    end
    // Abort on the third word: the first two stay written.
    word_src.delete();
    word_src.push_back(rand_word());
    word_src.push_back(rand_word());
    word_src.push_back({8'($urandom_range(255, 64)), 32'($urandom)});
    model_load(3);
    clear_mon();
    pulse_start();
    send_stream(1, -1);
    wait_idle();
    n_checks++;
    if (err !== 1'b1 || got_addr.size() !== exp_addr.size() || words_loaded !== 13'(exp_words) || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL bad_byte0_third: err=%b writes=%0d words=%0d required 1 %0d %0d", err, got_addr.size(), words_loaded, exp_addr.size(), exp_words);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL bad_byte0_partial[%0d]: got %0h@%0h required %0h@%0h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_gaps_start();
    word_src.delete();
    word_src.push_back(40'h04_0000_0001);
    word_src.push_back(40'h00_0000_0000);
    model_load(2);
    clear_mon();
    pulse_start();
    send_stream(4, 4);
    wait_idle();
    n_checks++;
    if (got_addr.size() !== exp_addr.size() || done_cnt !== 1 || words_loaded !== 13'd2) begin
      n_fail++;
      $display("FAIL gaps_summary: writes=%0d done=%0d words=%0d required 2 1 2", got_addr.size(), done_cnt, words_loaded);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL gaps_word[%0d]: got %0h@%0h required %0h@%0h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    word_src.delete();
    word_src.push_back(40'h04_0000_0001);
    word_src.push_back(40'h00_0000_0000);
    model_load(2);
    clear_mon();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_ready, mem_we, cpu_hold, busy, done, err} !== 6'b000000 ||
        mem_addr !== '0 || mem_wdata !== '0 || words_loaded !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: flags=%b addr=%0h wdata=%0h words=%0d required all 0",
               {rx_ready, mem_we, cpu_hold, busy, done, err}, mem_addr, mem_wdata, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    pulse_start();
    send_stream(0, -1);
    wait_idle();
    n_checks++;
    if (got_addr.size() !== 2 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL midload_reload_count: writes=%0d done=%0d required 2 1", got_addr.size(), done_cnt);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL midload_reload[%0d]: got %0h@%0h required %0h@%0h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_random();
    int count;
    for (int it = 0; it < 5; it++) begin
      count = int'($urandom_range(12, 1));
      word_src.delete();
      for (int w = 0; w < count; w++) word_src.push_back(rand_word());
      model_load(count);
      clear_mon();
      pulse_start();
      send_stream(int'($urandom_range(2, 0)), int'($urandom_range(8, 2)));
      wait_idle();
      n_checks++;
      if (got_addr.size() !== exp_addr.size() || done_cnt !== 1 || words_loaded !== 13'(exp_words) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL random_summary[%0d]: writes=%0d done=%0d words=%0d err=%b required %0d 1 %0d 0",
                 it, got_addr.size(), done_cnt, words_loaded, err, exp_addr.size(), exp_words);
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL random_word[%0d][%0d]: got %0h@%0h required %0h@%0h", it, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int start_cyc;
    int count;
    for (int it = 0; it < 2; it++) begin
      count = 3 + it;
      word_src.delete();
      for (int w = 0; w < count; w++) word_src.push_back(rand_word());
      model_load(count);
      clear_mon();
      pulse_start();
      start_cyc = cyc;
      send_stream(0, -1);
      wait_idle();
      // Two header bytes, then 5 bytes + one write cycle per word, then DONE.
      n_checks++;
      if (done_cnt !== 1 || done_cyc - start_cyc !== 6 * count + 2) begin
        n_fail++;
        $display("FAIL b2b_throughput[%0d]: done=%0d cycles=%0d required 1 %0d", it, done_cnt, done_cyc - start_cyc, 6 * count + 2);
      end
      n_checks++;
      if (got_addr.size() !== exp_addr.size()) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: writes=%0d required %0d", it, got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL b2b_word[%0d][%0d]: got %0h@%0h required %0h@%0h", it, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_max_count();
    word_src.delete();
    for (int w = 0; w < (1 << AW); w++) word_src.push_back(rand_word());
    model_load(1 << AW);
    clear_mon();
    pulse_start();
    send_stream(0, -1);
    wait_idle();
    n_checks++;
    if (got_addr.size() !== 4096 || words_loaded !== 13'd4096 || done_cnt !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL max_summary: writes=%0d words=%0d done=%0d err=%b required 4096 4096 1 0", got_addr.size(), words_loaded, done_cnt, err);
    end
    n_checks++;
    if (got_addr.size() > 0 && got_addr[got_addr.size() - 1] !== 12'hFFF) begin
      n_fail++;
      $display("FAIL max_last_addr: got %0h required fff", got_addr[got_addr.size() - 1]);
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL max_word[%0d]: got %0h@%0h required %0h@%0h", i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_header(0, "zero_count");
    test_bad_header(4097, "over_count");
    test_bad_byte0();
    test_gaps_start();
    test_reset_midload();
    test_random();
    test_back_to_back();
    test_max_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
